// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, taken-branch
// flushes, multi-cycle mul/div occupancy, halt drain, plus cycle/stall counters.
module pipeline_hazard_controller #(
    parameter int unsigned MULDIV_LAT   = 4,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic [31:0] ID_instruction,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        MemreadE,
    input  logic [4:0]  rt_E,
    input  logic        branch_taken_E,
    output logic        PC_write,
    output logic        IF_ID_write,
    output logic        IF_flush,
    output logic        ID_EX_bubble,
    output logic        muldiv_busy,
    output logic        halted,
    output logic [31:0] cycle_count,
    output logic [31:0] stall_count
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1,
        DRAIN   = 2'd2,
        HALTED  = 2'd3
    } state_e;

    localparam logic [3:0] MD_LOAD    = 4'(MULDIV_LAT - 1);
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] cycle_count_q, cycle_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    logic is_halt;
    logic is_muldiv;
    logic load_use;
    logic count_en;

    assign is_halt   = (ID_instruction == '1);
    // mult/multu/div/divu: opcode 0, funct 0x18..0x1B
    assign is_muldiv = (ID_instruction[31:26] == 6'd0) && (ID_instruction[5:2] == 4'b0110);
    assign load_use  = MemreadE && (rt_E != '0) && ((rt_E == ID_rs) || (rt_E == ID_rt));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        PC_write     = 1'b1;
        IF_ID_write  = 1'b1;
        IF_flush     = 1'b0;
        ID_EX_bubble = 1'b0;
        muldiv_busy  = 1'b0;
        halted       = 1'b0;

        unique case (state_q)
            RUN: begin
                if (branch_taken_E) begin
                    IF_flush     = 1'b1;
                    ID_EX_bubble = 1'b1;
                end else if (is_halt) begin
                    PC_write     = 1'b0;
                    IF_ID_write  = 1'b0;
                    ID_EX_bubble = 1'b1;
                    cnt_d        = DRAIN_LOAD;
                    state_d      = (DRAIN_CYCLES <= 1) ? HALTED : DRAIN;
                end else if (load_use) begin
                    PC_write     = 1'b0;
                    IF_ID_write  = 1'b0;
                    ID_EX_bubble = 1'b1;
                end else if (is_muldiv && (MULDIV_LAT > 1)) begin
                    cnt_d   = MD_LOAD;
                    state_d = MD_WAIT;
                end
            end
            MD_WAIT: begin
                PC_write     = 1'b0;
                IF_ID_write  = 1'b0;
                ID_EX_bubble = 1'b1;
                muldiv_busy  = 1'b1;
                cnt_d        = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = RUN;
            end
            DRAIN: begin
                PC_write     = 1'b0;
                IF_ID_write  = 1'b0;
                ID_EX_bubble = 1'b1;
                cnt_d        = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = HALTED;
            end
            HALTED: begin
                PC_write     = 1'b0;
                IF_ID_write  = 1'b0;
                ID_EX_bubble = 1'b1;
                halted       = 1'b1;
            end
            default: state_d = RUN;
        endcase

        // Disabled cycles freeze state but still report busy/halted status
        if (!ENABLE) begin
            state_d      = state_q;
            cnt_d        = cnt_q;
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            IF_flush     = 1'b0;
            ID_EX_bubble = 1'b0;
        end

        if (RESET) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            IF_flush     = 1'b1;
            ID_EX_bubble = 1'b1;
            muldiv_busy  = 1'b0;
            halted       = 1'b0;
        end
    end

    assign count_en      = ENABLE && (state_q != HALTED);
    assign cycle_count_d = count_en ? cycle_count_q + 32'd1 : cycle_count_q;
    assign stall_count_d = (count_en && !PC_write) ? stall_count_q + 32'd1 : stall_count_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= RUN;
            cnt_q         <= '0;
            cycle_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cycle_count_q <= cycle_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign cycle_count = cycle_count_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: a cycle-level reference model
// checked every negedge, plus hand-computed literal expectations per scenario.
module tb_pipeline_hazard_controller;

    localparam int unsigned LAT = 4;
    localparam int unsigned DRN = 4;

    logic        CLK = 1'b0;
    logic        RESET, ENABLE;
    logic [31:0] ID_instruction;
    logic [4:0]  ID_rs, ID_rt, rt_E;
    logic        MemreadE, branch_taken_E;
    logic        PC_write, IF_ID_write, IF_flush, ID_EX_bubble, muldiv_busy, halted;
    logic [31:0] cycle_count, stall_count;

    pipeline_hazard_controller #(
        .MULDIV_LAT  (LAT),
        .DRAIN_CYCLES(DRN)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .ENABLE        (ENABLE),
        .ID_instruction(ID_instruction),
        .ID_rs         (ID_rs),
        .ID_rt         (ID_rt),
        .MemreadE      (MemreadE),
        .rt_E          (rt_E),
        .branch_taken_E(branch_taken_E),
        .PC_write      (PC_write),
        .IF_ID_write   (IF_ID_write),
        .IF_flush      (IF_flush),
        .ID_EX_bubble  (ID_EX_bubble),
        .muldiv_busy   (muldiv_busy),
        .halted        (halted),
        .cycle_count   (cycle_count),
        .stall_count   (stall_count)
    );

    always #5 CLK = ~CLK;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining stall cycles rather than a state machine
    int          md_left    = 0;
    int          drain_left = 0;
    bit          m_halted   = 1'b0;
    logic [31:0] m_cyc      = '0;
    logic [31:0] m_stall    = '0;

    function automatic bit m_is_muldiv(input logic [31:0] ins);
        logic [5:0] op, fn;
        op = ins[31:26];
        fn = ins[5:0];
        return (op == 6'h00) && (fn inside {[6'h18:6'h1B]});
    endfunction

    always @(negedge CLK) begin
        logic e_pc, e_ifid, e_fl, e_bub, e_busy, e_halt;
        bit lu, hlt;
        lu  = MemreadE && (rt_E != 5'd0) && ((rt_E == ID_rs) || (rt_E == ID_rt));
        hlt = (ID_instruction == 32'hFFFF_FFFF);

        chk("cycle_count", cycle_count, m_cyc);
        chk("stall_count", stall_count, m_stall);

        e_pc = 1; e_ifid = 1; e_fl = 0; e_bub = 0;
        e_busy = (md_left > 0);
        e_halt = m_halted;
        if (m_halted || md_left > 0 || drain_left > 0) begin
            e_pc = 0; e_ifid = 0; e_bub = 1;
        end else if (branch_taken_E) begin
            e_fl = 1; e_bub = 1;
        end else if (hlt || lu) begin
            e_pc = 0; e_ifid = 0; e_bub = 1;
        end
        if (!ENABLE) begin
            e_pc = 0; e_ifid = 0; e_fl = 0; e_bub = 0;
        end
        if (RESET) begin
            e_pc = 0; e_ifid = 0; e_fl = 1; e_bub = 1; e_busy = 0; e_halt = 0;
        end

        chk("PC_write",     {31'd0, PC_write},     {31'd0, e_pc});
        chk("IF_ID_write",  {31'd0, IF_ID_write},  {31'd0, e_ifid});
        chk("IF_flush",     {31'd0, IF_flush},     {31'd0, e_fl});
        chk("ID_EX_bubble", {31'd0, ID_EX_bubble}, {31'd0, e_bub});
        chk("muldiv_busy",  {31'd0, muldiv_busy},  {31'd0, e_busy});
        chk("halted",       {31'd0, halted},       {31'd0, e_halt});

        if (RESET) begin
            md_left = 0; drain_left = 0; m_halted = 0; m_cyc = '0; m_stall = '0;
        end else if (ENABLE && !m_halted) begin
            m_cyc = m_cyc + 32'd1;
            if (!e_pc) m_stall = m_stall + 32'd1;
            if (md_left > 0) md_left--;
            else if (drain_left > 0) begin
                drain_left--;
                if (drain_left == 0) m_halted = 1;
            end else if (branch_taken_E) begin
            end else if (hlt) begin
                drain_left = int'(DRN) - 1;
                if (drain_left == 0) m_halted = 1;
            end else if (lu) begin
            end else if (m_is_muldiv(ID_instruction)) begin
                md_left = int'(LAT) - 1;
            end
        end
    end

    task automatic drive(input logic rst, input logic en, input logic [31:0] ins,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic mr, input logic [4:0] rte, input logic br);
        RESET = rst; ENABLE = en; ID_instruction = ins; ID_rs = rs; ID_rt = rt;
        MemreadE = mr; rt_E = rte; branch_taken_E = br;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic normal();
        drive(0, 1, 32'h0, 5'd1, 5'd2, 0, 5'd0, 0);
    endtask

    task automatic do_reset();
        drive(1, 1, 32'h0, 5'd0, 5'd0, 0, 5'd0, 0);
        tick();
        tick();
        normal();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        drive(1, 1, 32'h0, 5'd0, 5'd0, 0, 5'd0, 0);
        tick();
        tick();
        chk("rst_pc",    {31'd0, PC_write}, 32'd0);
        chk("rst_flush", {31'd0, IF_flush}, 32'd1);
        chk("rst_cyc",   cycle_count, 32'd0);
        chk("rst_stall", stall_count, 32'd0);

        // load-use, then same pattern with rt_E=0
        normal();
        drive(0, 1, 32'h0, 5'd8, 5'd3, 1, 5'd8, 0);
        #1 chk("lu_pc", {31'd0, PC_write}, 32'd0);
        chk("lu_bub", {31'd0, ID_EX_bubble}, 32'd1);
        tick();
        normal();
        #1 chk("lu_after_pc", {31'd0, PC_write}, 32'd1);
        tick();
        chk("lu_stall", stall_count, 32'd1);
        chk("lu_cyc",   cycle_count, 32'd2);
        drive(0, 1, 32'h0, 5'd0, 5'd0, 1, 5'd0, 0);
        #1 chk("rt0_pc", {31'd0, PC_write}, 32'd1);
        tick();
        chk("rt0_stall", stall_count, 32'd1);
        chk("rt0_cyc",   cycle_count, 32'd3);

        // branch beats load-use
        do_reset();
        drive(0, 1, 32'h0, 5'd8, 5'd3, 1, 5'd8, 1);
        #1 chk("br_flush", {31'd0, IF_flush}, 32'd1);
        chk("br_bub", {31'd0, ID_EX_bubble}, 32'd1);
        chk("br_pc",  {31'd0, PC_write}, 32'd1);
        tick();
        normal();
        tick();
        chk("br_stall", stall_count, 32'd0);
        chk("br_cyc",   cycle_count, 32'd2);

        // mul/div occupancy, branch during MD_WAIT ignored
        do_reset();
        drive(0, 1, 32'h0000_0018, 5'd1, 5'd2, 0, 5'd0, 0);
        #1 chk("md_issue_pc", {31'd0, PC_write}, 32'd1);
        tick();
        chk("md_busy1", {31'd0, muldiv_busy}, 32'd1);
        normal();
        tick();
        drive(0, 1, 32'h0, 5'd1, 5'd2, 0, 5'd0, 1);
        #1 chk("md_br_flush", {31'd0, IF_flush}, 32'd0);
        tick();
        chk("md_busy3", {31'd0, muldiv_busy}, 32'd1);
        normal();
        #1 chk("md_last_pc", {31'd0, PC_write}, 32'd0);
        tick();
        chk("md_done", {31'd0, muldiv_busy}, 32'd0);
        tick();
        chk("md_stall", stall_count, 32'd3);
        chk("md_cyc",   cycle_count, 32'd5);

        // ENABLE low for 3 cycles mid MD_WAIT
        do_reset();
        drive(0, 1, 32'h0000_001B, 5'd1, 5'd2, 0, 5'd0, 0);
        tick();
        normal();
        tick();
        drive(0, 0, 32'h0, 5'd1, 5'd2, 0, 5'd0, 0);
        tick(); tick(); tick();
        chk("en_busy_hold", {31'd0, muldiv_busy}, 32'd1);
        chk("en_cyc_hold",   cycle_count, 32'd2);
        chk("en_stall_hold", stall_count, 32'd1);
        normal();
        tick();
        chk("en_busy_ext", {31'd0, muldiv_busy}, 32'd1);
        tick();
        chk("en_busy_end", {31'd0, muldiv_busy}, 32'd0);
        tick();
        chk("en_cyc",   cycle_count, 32'd5);
        chk("en_stall", stall_count, 32'd3);

        // halt drain
        do_reset();
        drive(0, 1, 32'hFFFF_FFFF, 5'd1, 5'd2, 0, 5'd0, 0);
        #1 chk("halt_detect_pc", {31'd0, PC_write}, 32'd0);
        tick();
        chk("halt_e1", {31'd0, halted}, 32'd0);
        normal();
        tick();
        tick();
        chk("halt_e3", {31'd0, halted}, 32'd0);
        tick();
        chk("halt_e4", {31'd0, halted}, 32'd1);
        chk("halt_pc", {31'd0, PC_write}, 32'd0);
        tick(); tick(); tick();
        chk("halt_hold",  {31'd0, halted}, 32'd1);
        chk("halt_cyc",   cycle_count, 32'd4);
        chk("halt_stall", stall_count, 32'd4);

        // reset aborts a drain
        do_reset();
        drive(0, 1, 32'hFFFF_FFFF, 5'd1, 5'd2, 0, 5'd0, 0);
        tick();
        normal();
        tick();
        tick();
        drive(1, 1, 32'h0, 5'd0, 5'd0, 0, 5'd0, 0);
        tick();
        normal();
        #1 chk("abort_halted", {31'd0, halted}, 32'd0);
        chk("abort_pc",    {31'd0, PC_write}, 32'd1);
        chk("abort_cyc",   cycle_count, 32'd0);
        chk("abort_stall", stall_count, 32'd0);
        tick();
        chk("abort_cyc1", cycle_count, 32'd1);

        // cycle counter wrap
        #1 force dut.cycle_count_q = 32'hFFFF_FFFF;
        m_cyc = 32'hFFFF_FFFF;
        #1 release dut.cycle_count_q;
        tick();
        chk("wrap", cycle_count, 32'd0);
        tick();
        chk("wrap_next", cycle_count, 32'd1);

        @(negedge CLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
